fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_pkg.sv | 17 +
 rtl/stream_skid_buf.sv | 60 ++++++
 rtl/fifo_stream_reader.sv | 106 ++++++++++
 tb/tb_fifo_stream_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO and its stream reader.
// The reader's state encoding lives here so the bench and RTL share one definition.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 9;
    localparam int unsigned DEF_LEN_WIDTH   = 8;
    localparam int unsigned FIFO_ADDR_WIDTH = 4;
    localparam int unsigned FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;
    localparam int unsigned SKID_DEPTH      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } reader_state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer; the head register drives the downstream stream directly.
// A slot is free when not full, or when full but the head is leaving this cycle.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int P_DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [P_DATA_WIDTH-1:0] push_data,
    input  logic                    pop,
    output logic [P_DATA_WIDTH-1:0] head_data,
    output logic                    head_valid,
    output logic                    slot_free
);

    localparam logic [1:0] FULL = 2'(SKID_DEPTH);

    logic [1:0]              occ;
    logic [P_DATA_WIDTH-1:0] tail_data;

    assign head_valid = (occ != 2'd0);
    assign slot_free  = (occ != FULL) || pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            head_data <= '0;
            tail_data <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= push_data;
                        occ       <= 2'd1;
                    end else if (occ == 2'd1) begin
                        tail_data <= push_data;
                        occ       <= FULL;
                    end
                end
                2'b01: begin
                    if (occ == FULL) head_data <= tail_data;
                    if (occ != 2'd0) occ <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word goes behind whatever remains.
                    if (occ == 2'd1) begin
                        head_data <= push_data;
                    end else if (occ == FULL) begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a burst of BURST_LEN words from the async FIFO read side and streams them
// downstream with valid/ready, marking the final word with OUT_LAST.
//
// state     | meaning
// ----------|------------------------------------------------
// ST_IDLE   | waiting for START; counters hold
// ST_STREAM | popping FIFO into skid buffer, delivering words
// ST_FINISH | one-cycle DONE pulse, then back to idle
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int P_LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                    R_CLK,
    input  logic                    RRST,
    input  logic                    START,
    input  logic [P_LEN_WIDTH-1:0]  BURST_LEN,
    input  logic                    EMPTY,
    input  logic [P_DATA_WIDTH-1:0] DATA_OUT,
    output logic                    R_EN,
    output logic [P_DATA_WIDTH-1:0] OUT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    OUT_LAST,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam logic [P_LEN_WIDTH-1:0] ONE = P_LEN_WIDTH'(1);

    reader_state_t          state, state_nxt;
    logic [P_LEN_WIDTH-1:0] pop_cnt;
    logic [P_LEN_WIDTH-1:0] send_cnt;
    logic                   slot_free;
    logic                   handshake;
    logic                   start_ok;

    assign handshake = OUT_VALID && OUT_READY;
    assign start_ok  = (state == ST_IDLE) && START;
    assign OUT_LAST  = OUT_VALID && (send_cnt == ONE);

    stream_skid_buf #(
        .P_DATA_WIDTH (P_DATA_WIDTH)
    ) u_skid (
        .clk        (R_CLK),
        .rst        (RRST),
        .push       (R_EN),
        .push_data  (DATA_OUT),
        .pop        (handshake),
        .head_data  (OUT_DATA),
        .head_valid (OUT_VALID),
        .slot_free  (slot_free)
    );

    always_ff @(posedge R_CLK) begin
        if (RRST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (START) state_nxt = (BURST_LEN != '0) ? ST_STREAM : ST_FINISH;
            end
            ST_STREAM: begin
                if (handshake && OUT_LAST) state_nxt = ST_FINISH;
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        R_EN = 1'b0;
        case (state)
            ST_STREAM: begin
                BUSY = 1'b1;
                R_EN = !EMPTY && (pop_cnt != '0) && slot_free;
            end
            ST_FINISH: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    // Both counters are down-counters guarded against wrapping below zero.
    always_ff @(posedge R_CLK) begin
        if (RRST) begin
            pop_cnt  <= '0;
            send_cnt <= '0;
        end else if (start_ok) begin
            pop_cnt  <= BURST_LEN;
            send_cnt <= BURST_LEN;
        end else begin
            if (R_EN && (pop_cnt != '0))        pop_cnt  <= pop_cnt - ONE;
            if (handshake && (send_cnt != '0))  send_cnt <= send_cnt - ONE;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a queue-backed FIFO model on the read side.
// Outputs are sampled 1-2 time units after the rising edge.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    logic       R_CLK = 1'b0;
    logic       RRST;
    logic       START;
    logic [7:0] BURST_LEN;
    logic       EMPTY;
    logic [8:0] DATA_OUT;
    logic       R_EN;
    logic [8:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       OUT_LAST;
    logic       BUSY;
    logic       DONE;

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    int en_while_empty = 0;
    bit force_empty = 1'b0;

    logic [8:0] fifo_q[$];
    logic [8:0] got_data[$];
    logic       got_last[$];

    logic [8:0] wa[4] = '{9'h1A1, 9'h0B2, 9'h0C3, 9'h1D4};
    logic [8:0] wb[3] = '{9'h011, 9'h022, 9'h033};
    logic [8:0] wc[5] = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h105};
    logic [8:0] wd[6] = '{9'h0F0, 9'h0F1, 9'h0F2, 9'h0F3, 9'h0F4, 9'h0F5};
    logic [8:0] we[2] = '{9'h155, 9'h0AA};

    fifo_stream_reader #(
        .P_DATA_WIDTH (9),
        .P_LEN_WIDTH  (8)
    ) dut (
        .R_CLK     (R_CLK),
        .RRST      (RRST),
        .START     (START),
        .BURST_LEN (BURST_LEN),
        .EMPTY     (EMPTY),
        .DATA_OUT  (DATA_OUT),
        .R_EN      (R_EN),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LAST  (OUT_LAST),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 R_CLK = ~R_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        EMPTY    = force_empty || (fifo_q.size() == 0);
        DATA_OUT = (fifo_q.size() != 0) ? fifo_q[0] : 9'h000;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        bit pop_now;
        pop_now = (R_EN === 1'b1);
        if (R_EN === 1'b1 && EMPTY) en_while_empty++;
        if (OUT_VALID === 1'b1 && OUT_READY) begin
            got_data.push_back(OUT_DATA);
            got_last.push_back(OUT_LAST);
        end
        @(posedge R_CLK);
        #1;
        if (pop_now) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pops++;
        end
        drive_fifo();
        #1;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (DONE !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", 32'(DONE), 32'd1);
        tick();
        check("busy_after_done", 32'(BUSY), 32'd0);
    endtask

    initial begin
        RRST = 1'b1; START = 1'b0; BURST_LEN = 8'd0; OUT_READY = 1'b0;
        drive_fifo();
        tick(); tick();
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_last",  32'(OUT_LAST),  32'd0);
        check("rst_busy",      32'(BUSY),      32'd0);
        check("rst_done",      32'(DONE),      32'd0);
        check("rst_r_en",      32'(R_EN),      32'd0);
        check("rst_out_data",  32'(OUT_DATA),  32'd0);
        RRST = 1'b0;
        tick();

        // Basic 4-word burst at full rate
        foreach (wa[i]) fifo_q.push_back(wa[i]);
        drive_fifo();
        got_data.delete(); got_last.delete(); pops = 0;
        START = 1'b1; BURST_LEN = 8'd4; OUT_READY = 1'b1; settle();
        check("s1_idle_no_ren", 32'(R_EN), 32'd0);
        tick();
        START = 1'b0; settle();
        check("s1_busy", 32'(BUSY), 32'd1);
        check("s1_ren_first", 32'(R_EN), 32'd1);
        check("s1_valid_before", 32'(OUT_VALID), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("s1_data%0d", i), 32'(OUT_DATA), 32'(wa[i]));
            check($sformatf("s1_valid%0d", i), 32'(OUT_VALID), 32'd1);
            check($sformatf("s1_last%0d", i), 32'(OUT_LAST), (i == 3) ? 32'd1 : 32'd0);
            check($sformatf("s1_ren%0d", i), 32'(R_EN), (i < 3) ? 32'd1 : 32'd0);
        end
        tick();
        check("s1_done", 32'(DONE), 32'd1);
        check("s1_busy_finish", 32'(BUSY), 32'd1);
        check("s1_valid_finish", 32'(OUT_VALID), 32'd0);
        tick();
        check("s1_done_pulse", 32'(DONE), 32'd0);
        check("s1_busy_drop", 32'(BUSY), 32'd0);
        check("s1_pops", 32'(pops), 32'd4);

        // Backpressure: ready low for 5 cycles, only 2 pops fit the buffer
        foreach (wb[i]) fifo_q.push_back(wb[i]);
        drive_fifo();
        got_data.delete(); got_last.delete(); pops = 0;
        OUT_READY = 1'b0; START = 1'b1; BURST_LEN = 8'd3; settle();
        tick();
        START = 1'b0; settle();
        for (int i = 0; i < 5; i++) tick();
        check("s2_pops_stalled", 32'(pops), 32'd2);
        check("s2_data_held", 32'(OUT_DATA), 32'(wb[0]));
        check("s2_valid_held", 32'(OUT_VALID), 32'd1);
        check("s2_ren_blocked", 32'(R_EN), 32'd0);
        check("s2_last_held", 32'(OUT_LAST), 32'd0);
        OUT_READY = 1'b1; settle();
        check("s2_ren_on_ready", 32'(R_EN), 32'd1);
        tick();
        check("s2_data1", 32'(OUT_DATA), 32'(wb[1]));
        check("s2_pops3", 32'(pops), 32'd3);
        check("s2_ren_done", 32'(R_EN), 32'd0);
        tick();
        check("s2_data2", 32'(OUT_DATA), 32'(wb[2]));
        check("s2_last2", 32'(OUT_LAST), 32'd1);
        run_until_done(5);
        check("s2_count", 32'(got_data.size()), 32'd3);

        // FIFO runs empty for cycles 2-6 of a 5-word burst
        foreach (wc[i]) fifo_q.push_back(wc[i]);
        drive_fifo();
        got_data.delete(); got_last.delete(); pops = 0; en_while_empty = 0;
        START = 1'b1; BURST_LEN = 8'd5; settle();
        tick();
        START = 1'b0; settle();
        check("s3_ren_c1", 32'(R_EN), 32'd1);
        tick();
        force_empty = 1'b1; drive_fifo(); settle();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("s3_no_ren_empty%0d", i), 32'(R_EN), 32'd0);
            tick();
        end
        check("s3_pops_stalled", 32'(pops), 32'd1);
        force_empty = 1'b0; drive_fifo(); settle();
        run_until_done(20);
        check("s3_count", 32'(got_data.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_data.size()) begin
                check($sformatf("s3_word%0d", i), 32'(got_data[i]), 32'(wc[i]));
                check($sformatf("s3_lastflag%0d", i), 32'(got_last[i]), (i == 4) ? 32'd1 : 32'd0);
            end
        end
        check("s3_ren_while_empty", 32'(en_while_empty), 32'd0);

        // Zero-length burst
        fifo_q.push_back(9'h1FF);
        drive_fifo();
        pops = 0;
        START = 1'b1; BURST_LEN = 8'd0; settle();
        tick();
        START = 1'b0; settle();
        check("s4_done", 32'(DONE), 32'd1);
        check("s4_ren", 32'(R_EN), 32'd0);
        check("s4_valid", 32'(OUT_VALID), 32'd0);
        tick();
        check("s4_done_pulse", 32'(DONE), 32'd0);
        check("s4_pops", 32'(pops), 32'd0);
        fifo_q.delete(); drive_fifo();

        // Reset after 2 of 6 words delivered, then a fresh burst
        foreach (wd[i]) fifo_q.push_back(wd[i]);
        drive_fifo();
        got_data.delete(); got_last.delete();
        START = 1'b1; BURST_LEN = 8'd6; settle();
        tick();
        START = 1'b0; settle();
        tick(); tick(); tick();
        check("s5_delivered", 32'(got_data.size()), 32'd2);
        RRST = 1'b1; settle();
        tick();
        check("s5_rst_valid", 32'(OUT_VALID), 32'd0);
        check("s5_rst_busy", 32'(BUSY), 32'd0);
        check("s5_rst_done", 32'(DONE), 32'd0);
        check("s5_rst_ren", 32'(R_EN), 32'd0);
        RRST = 1'b0;
        fifo_q.delete();
        foreach (we[i]) fifo_q.push_back(we[i]);
        drive_fifo();
        got_data.delete(); got_last.delete();
        START = 1'b1; BURST_LEN = 8'd2; settle();
        tick();
        START = 1'b0; settle();
        run_until_done(20);
        check("s5_count", 32'(got_data.size()), 32'd2);
        if (got_data.size() == 2) begin
            check("s5_word0", 32'(got_data[0]), 32'(we[0]));
            check("s5_word1", 32'(got_data[1]), 32'(we[1]));
            check("s5_last1", 32'(got_last[1]), 32'd1);
        end

        // START re-pulsed while busy must not change the burst
        fifo_q.delete();
        foreach (wd[i]) fifo_q.push_back(wd[i]);
        drive_fifo();
        got_data.delete(); got_last.delete(); pops = 0;
        START = 1'b1; BURST_LEN = 8'd3; settle();
        tick();
        BURST_LEN = 8'd5; settle();
        tick(); tick(); tick();
        START = 1'b0; settle();
        run_until_done(20);
        check("s6_count", 32'(got_data.size()), 32'd3);
        check("s6_pops", 32'(pops), 32'd3);
        check("s6_fifo_left", 32'(fifo_q.size()), 32'd3);
        if (got_data.size() == 3) begin
            check("s6_word2", 32'(got_data[2]), 32'(wd[2]));
            check("s6_last2", 32'(got_last[2]), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
